// File: rtl/window_fetch_engine_if.sv
// Signal bundle between the window fetch engine, its memory read port and
// the window consumer. The engine side uses the master modport.
interface window_fetch_engine_if #(
  parameter int WIN    = 16,
  parameter int ADDR_W = 21
);
  logic                 start;
  logic                 abort;
  logic [ADDR_W-1:0]    base_addr;
  logic [7:0]           win_row;
  logic [7:0]           win_col;
  logic                 rd_req;
  logic [ADDR_W-1:0]    req_addr;
  logic [31:0]          rd_data;
  logic                 busy;
  logic                 win_valid;
  logic [WIN*WIN*8-1:0] win_data;
  logic                 range_err;

  modport master (
    input  start, abort, base_addr, win_row, win_col, rd_data,
    output rd_req, req_addr, busy, win_valid, win_data, range_err
  );

  modport slave (
    output start, abort, base_addr, win_row, win_col, rd_data,
    input  rd_req, req_addr, busy, win_valid, win_data, range_err
  );
endinterface

// File: rtl/window_fetch_engine.sv
// Gathers one WIN x WIN byte-pixel window from word-addressed memory, one
// 32-bit read per cycle, tolerating a fixed read latency of RD_LAT cycles.
module window_fetch_engine #(
  parameter int WIN       = 16,
  parameter int ROW_WORDS = 20,
  parameter int ADDR_W    = 21,
  parameter int RD_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  window_fetch_engine_if.master fetch_if
);

  localparam int N      = WIN * WIN / 4;
  localparam int WPR    = WIN / 4;
  localparam int IDX_W  = $clog2(N);
  localparam int WCNT_W = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [ADDR_W-1:0]  line_addr_q;
  logic [IDX_W-1:0]   issue_cnt_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic               range_err_q;
  logic               vld_q [RD_LAT];
  logic [IDX_W-1:0]   idx_q [RD_LAT];

  logic               range_ok;
  logic               start_ok;
  logic               accept;
  logic               reject;
  logic               issue_last;
  logic               row_end;
  logic               advance;
  logic               cap_en;
  logic               cap_last;
  logic [ADDR_W-1:0]  first_addr;

  assign range_ok   = (int'(fetch_if.win_col) + WPR) <= ROW_WORDS;
  // abort beats a simultaneous start, even from IDLE
  assign start_ok   = (state_q == IDLE) && fetch_if.start && !fetch_if.abort;
  assign accept     = start_ok && range_ok;
  assign reject     = start_ok && !range_ok;
  assign first_addr = fetch_if.base_addr
                    + ADDR_W'(fetch_if.win_row) * ADDR_W'(ROW_WORDS)
                    + ADDR_W'(fetch_if.win_col);

  assign issue_last = (issue_cnt_q == IDX_W'(N - 1));
  assign row_end    = (wcnt_q == WCNT_W'(WPR - 1));
  assign advance    = (state_q == ISSUE) && !issue_last && !fetch_if.abort;
  assign cap_en     = vld_q[RD_LAT-1] && !fetch_if.abort;
  assign cap_last   = cap_en && (idx_q[RD_LAT-1] == IDX_W'(N - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (issue_last) state_d = DRAIN;
      DRAIN:   if (cap_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fetch_if.abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address generator: req_addr walks a row, line_addr remembers the row start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      wcnt_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= reject;
      if (accept) begin
        req_addr_q  <= first_addr;
        line_addr_q <= first_addr;
        issue_cnt_q <= '0;
        wcnt_q      <= '0;
      end else if (advance) begin
        issue_cnt_q <= issue_cnt_q + IDX_W'(1);
        if (row_end) begin
          wcnt_q      <= '0;
          line_addr_q <= line_addr_q + ADDR_W'(ROW_WORDS);
          req_addr_q  <= line_addr_q + ADDR_W'(ROW_WORDS);
        end else begin
          wcnt_q     <= wcnt_q + WCNT_W'(1);
          req_addr_q <= req_addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Response tracker: stage RD_LAT-1 marks the cycle whose rd_data is ours
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_q[s] <= 1'b0;
        idx_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= (state_q == ISSUE) && !fetch_if.abort;
      idx_q[0] <= issue_cnt_q;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1] && !fetch_if.abort;
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_word
    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (cap_en && (idx_q[RD_LAT-1] == IDX_W'(gi))) begin
        word_q <= fetch_if.rd_data;
      end
    end

    assign fetch_if.win_data[gi*32 +: 32] = word_q;
  end

  assign fetch_if.rd_req    = (state_q == ISSUE);
  assign fetch_if.busy      = (state_q != IDLE);
  assign fetch_if.win_valid = (state_q == DONE);
  assign fetch_if.req_addr  = req_addr_q;
  assign fetch_if.range_err = range_err_q;

endmodule

// File: tb/tb_window_fetch_engine.sv
// Directed bench: three engines (RD_LAT 1, 2, 3) share stimulus, each with
// its own latency-matched memory model; each task checks one scenario.
module tb_window_fetch_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [20:0] base;
  logic [7:0]  row;
  logic [7:0]  col;
  int          mode;

  logic [2:0]         rd_req_a;
  logic [2:0]         busy_a;
  logic [2:0]         valid_a;
  logic [2:0]         rerr_a;
  logic [2:0][20:0]   req_addr_a;
  logic [2:0][2047:0] wdata_a;

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is derived from the absolute address only
  function automatic logic [31:0] mem_word(logic [20:0] addr);
    logic [20:0] off;
    int r, c, i, w;
    off = addr - base;
    r = int'(off) / 20;
    c = int'(off) % 20;
    i = r - int'(row);
    w = c - int'(col);
    case (mode)
      0:       return 32'h4044_4044;
      1:       return {8'(w), 8'(i), 8'(w), 8'(i)};
      default: return 32'hA500_0000 | 32'(addr);
    endcase
  endfunction

  function automatic logic [20:0] exp_addr(int i, int w);
    int a;
    a = int'(base) + (int'(row) + i) * 20 + int'(col) + w;
    return 21'(a);
  endfunction

  function automatic logic [31:0] exp_word(int md, int i, int w);
    case (md)
      0:       return 32'h4044_4044;
      1:       return {8'(w), 8'(i), 8'(w), 8'(i)};
      default: return 32'hA500_0000 | 32'(exp_addr(i, w));
    endcase
  endfunction

  function automatic logic [2047:0] exp_window(int md);
    logic [2047:0] v;
    logic [31:0]   wd;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        wd = exp_word(md, i, j / 4);
        v[(i*16+j)*8 +: 8] = wd[(j%4)*8 +: 8];
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] pix(logic [2047:0] wd, int i, int j);
    return wd[(i*16+j)*8 +: 8];
  endfunction

  function automatic int first_diff(logic [2047:0] a, logic [2047:0] b);
    for (int p = 0; p < 256; p++) if (a[p*8 +: 8] !== b[p*8 +: 8]) return p;
    return 0;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    logic [31:0] pipe [LAT];

    window_fetch_engine_if #(.WIN(16), .ADDR_W(21)) ifc ();

    assign ifc.start     = start;
    assign ifc.abort     = abort;
    assign ifc.base_addr = base;
    assign ifc.win_row   = row;
    assign ifc.win_col   = col;
    assign ifc.rd_data   = pipe[LAT-1];

    always @(posedge clk) begin
      pipe[0] <= mem_word(ifc.req_addr);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end

    window_fetch_engine #(.WIN(16), .ROW_WORDS(20), .ADDR_W(21), .RD_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetch_if (ifc)
    );

    assign rd_req_a[gi]   = ifc.rd_req;
    assign busy_a[gi]     = ifc.busy;
    assign valid_a[gi]    = ifc.win_valid;
    assign rerr_a[gi]     = ifc.range_err;
    assign req_addr_a[gi] = ifc.req_addr;
    assign wdata_a[gi]    = ifc.win_data;
  end

  // Starts a fetch sampled at edge 0, then observes cycles 1..ncyc of instance lat
  task automatic run_window(input int lat, input int ncyc, input int abort_cyc,
                            input int s1, input int s2,
                            output int nreq, output int vcyc, output int vcnt,
                            output int bcnt, output int aerr, output int rcnt);
    int l;
    l = lat - 1;
    nreq = 0; vcyc = -1; vcnt = 0; bcnt = 0; aerr = 0; rcnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = (c == s1) || (c == s2);
      abort = (c == abort_cyc);
      if (rd_req_a[l]) begin
        if (req_addr_a[l] !== exp_addr(nreq / 4, nreq % 4)) aerr++;
        nreq++;
      end
      if (valid_a[l]) begin
        if (vcyc < 0) vcyc = c;
        vcnt++;
      end
      if (busy_a[l]) bcnt++;
      if (rerr_a[l]) rcnt++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (rd_req_a !== 3'b000) begin tests_failed++; $display("FAIL reset_rd_req: got %b expected 000", rd_req_a); end
    tests_run++; if (busy_a !== 3'b000) begin tests_failed++; $display("FAIL reset_busy: got %b expected 000", busy_a); end
    tests_run++; if (valid_a !== 3'b000) begin tests_failed++; $display("FAIL reset_win_valid: got %b expected 000", valid_a); end
    tests_run++; if (rerr_a !== 3'b000) begin tests_failed++; $display("FAIL reset_range_err: got %b expected 000", rerr_a); end
    tests_run++; if (req_addr_a !== '0) begin tests_failed++; $display("FAIL reset_req_addr: got %h expected 0", req_addr_a); end
    tests_run++; if (wdata_a !== '0) begin tests_failed++; $display("FAIL reset_win_data: got nonzero expected 0"); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (busy_a !== 3'b000) begin tests_failed++; $display("FAIL reset_idle_busy: got %b expected 000", busy_a); end
    $display("[TB] reset: outputs idle");
  endtask

  task automatic test_basic();
    int nreq, vcyc, vcnt, bcnt, aerr, rcnt, d;
    mode = 0; base = 21'd65; row = 8'd0; col = 8'd0;
    run_window(1, 72, -1, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (nreq !== 64) begin tests_failed++; $display("FAIL basic_nreq: got %0d expected 64", nreq); end
    tests_run++; if (aerr !== 0) begin tests_failed++; $display("FAIL basic_addr: got %0d bad addresses expected 0", aerr); end
    tests_run++; if (req_addr_a[0] !== 21'd368) begin tests_failed++; $display("FAIL basic_last_addr: got %0d expected 368", req_addr_a[0]); end
    tests_run++; if (vcyc !== 66) begin tests_failed++; $display("FAIL basic_valid_cycle: got %0d expected 66", vcyc); end
    tests_run++; if (vcnt !== 1) begin tests_failed++; $display("FAIL basic_valid_count: got %0d expected 1", vcnt); end
    tests_run++; if (bcnt !== 66) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d expected 66", bcnt); end
    tests_run++; if (pix(wdata_a[0], 0, 0) !== 8'h44) begin tests_failed++; $display("FAIL basic_pix00: got %h expected 44", pix(wdata_a[0], 0, 0)); end
    tests_run++; if (pix(wdata_a[0], 15, 1) !== 8'h40) begin tests_failed++; $display("FAIL basic_pix15_1: got %h expected 40", pix(wdata_a[0], 15, 1)); end
    tests_run++;
    if (wdata_a[2] !== exp_window(0)) begin
      tests_failed++; d = first_diff(wdata_a[2], exp_window(0));
      $display("FAIL basic_window_lat3: pixel %0d got %h expected %h", d, wdata_a[2][d*8 +: 8], exp_window(0) >> (d*8));
    end
    $display("[TB] basic: %0d reqs, win_valid at cycle %0d", nreq, vcyc);
  endtask

  task automatic test_offset();
    int nreq, vcyc, vcnt, bcnt, aerr, rcnt, d;
    logic [2047:0] ex;
    mode = 1; base = 21'd65; row = 8'd3; col = 8'd2;
    ex = exp_window(1);
    run_window(3, 72, -1, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (exp_addr(0, 0) !== 21'd127) begin tests_failed++; $display("FAIL offset_first_addr_model: got %0d expected 127", exp_addr(0, 0)); end
    tests_run++; if (aerr !== 0) begin tests_failed++; $display("FAIL offset_addr: got %0d bad addresses expected 0", aerr); end
    tests_run++; if (nreq !== 64) begin tests_failed++; $display("FAIL offset_nreq: got %0d expected 64", nreq); end
    tests_run++; if (vcyc !== 68) begin tests_failed++; $display("FAIL offset_valid_cycle: got %0d expected 68", vcyc); end
    tests_run++; if (bcnt !== 68) begin tests_failed++; $display("FAIL offset_busy_cycles: got %0d expected 68", bcnt); end
    tests_run++; if (pix(wdata_a[2], 5, 9) !== 8'h02) begin tests_failed++; $display("FAIL offset_pix5_9: got %h expected 02", pix(wdata_a[2], 5, 9)); end
    tests_run++; if (pix(wdata_a[2], 7, 12) !== 8'h07) begin tests_failed++; $display("FAIL offset_pix7_12: got %h expected 07", pix(wdata_a[2], 7, 12)); end
    tests_run++;
    if (wdata_a[2] !== ex) begin
      tests_failed++; d = first_diff(wdata_a[2], ex);
      $display("FAIL offset_window: pixel %0d got %h expected %h", d, wdata_a[2][d*8 +: 8], ex[d*8 +: 8]);
    end
    $display("[TB] offset: %0d reqs, win_valid at cycle %0d", nreq, vcyc);
  endtask

  task automatic test_range();
    int nreq, vcyc, vcnt, bcnt, aerr, rcnt;
    mode = 0; base = 21'd65; row = 8'd0; col = 8'd17;
    run_window(1, 6, -1, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (rcnt !== 1) begin tests_failed++; $display("FAIL range_err_pulses: got %0d expected 1", rcnt); end
    tests_run++; if (nreq !== 0) begin tests_failed++; $display("FAIL range_nreq: got %0d expected 0", nreq); end
    tests_run++; if (bcnt !== 0) begin tests_failed++; $display("FAIL range_busy: got %0d expected 0", bcnt); end
    tests_run++; if (vcnt !== 0) begin tests_failed++; $display("FAIL range_valid: got %0d expected 0", vcnt); end
    col = 8'd16;
    run_window(1, 6, 3, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (rcnt !== 0) begin tests_failed++; $display("FAIL range_edge_err: got %0d expected 0", rcnt); end
    tests_run++; if (nreq !== 3) begin tests_failed++; $display("FAIL range_edge_nreq: got %0d expected 3", nreq); end
    tests_run++; if (aerr !== 0) begin tests_failed++; $display("FAIL range_edge_addr: got %0d bad addresses expected 0", aerr); end
    $display("[TB] range: col 17 rejected, col 16 accepted");
  endtask

  task automatic test_abort();
    int nreq, vcyc, vcnt, bcnt, aerr, rcnt, d;
    logic [2047:0] ex;
    mode = 1; base = 21'd300; row = 8'd1; col = 8'd5;
    ex = exp_window(1);
    run_window(2, 40, 30, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (nreq !== 30) begin tests_failed++; $display("FAIL abort_nreq: got %0d expected 30", nreq); end
    tests_run++; if (bcnt !== 30) begin tests_failed++; $display("FAIL abort_busy_cycles: got %0d expected 30", bcnt); end
    tests_run++; if (vcnt !== 0) begin tests_failed++; $display("FAIL abort_valid: got %0d expected 0", vcnt); end
    run_window(2, 72, -1, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (vcyc !== 67) begin tests_failed++; $display("FAIL abort_restart_valid_cycle: got %0d expected 67", vcyc); end
    tests_run++; if (nreq !== 64) begin tests_failed++; $display("FAIL abort_restart_nreq: got %0d expected 64", nreq); end
    tests_run++; if (aerr !== 0) begin tests_failed++; $display("FAIL abort_restart_addr: got %0d bad addresses expected 0", aerr); end
    tests_run++;
    if (wdata_a[1] !== ex) begin
      tests_failed++; d = first_diff(wdata_a[1], ex);
      $display("FAIL abort_restart_window: pixel %0d got %h expected %h", d, wdata_a[1][d*8 +: 8], ex[d*8 +: 8]);
    end
    $display("[TB] abort: aborted after %0d reqs, restart valid at cycle %0d", 30, vcyc);
  endtask

  task automatic test_back_to_back();
    int nreq, vcyc, vcnt, bcnt, aerr, rcnt;
    mode = 1; base = 21'd200; row = 8'd0; col = 8'd0;
    run_window(1, 72, -1, 10, 66, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (vcnt !== 1) begin tests_failed++; $display("FAIL b2b_valid_count: got %0d expected 1", vcnt); end
    tests_run++; if (vcyc !== 66) begin tests_failed++; $display("FAIL b2b_valid_cycle: got %0d expected 66", vcyc); end
    tests_run++; if (nreq !== 64) begin tests_failed++; $display("FAIL b2b_nreq: got %0d expected 64", nreq); end
    tests_run++; if (bcnt !== 66) begin tests_failed++; $display("FAIL b2b_busy_cycles: got %0d expected 66", bcnt); end
    $display("[TB] back_to_back: starts at cycles 10 and 66 ignored");
  endtask

  task automatic test_wrap();
    int nreq, vcyc, vcnt, bcnt, aerr, rcnt, d;
    logic [2047:0] ex;
    mode = 2; base = 21'h1F_FFF6; row = 8'd0; col = 8'd0;
    ex = exp_window(2);
    run_window(1, 72, -1, -1, -1, nreq, vcyc, vcnt, bcnt, aerr, rcnt);
    tests_run++; if (aerr !== 0) begin tests_failed++; $display("FAIL wrap_addr: got %0d bad addresses expected 0", aerr); end
    tests_run++; if (vcyc !== 66) begin tests_failed++; $display("FAIL wrap_valid_cycle: got %0d expected 66", vcyc); end
    tests_run++; if (pix(wdata_a[0], 0, 0) !== 8'hF6) begin tests_failed++; $display("FAIL wrap_pix0_0: got %h expected f6", pix(wdata_a[0], 0, 0)); end
    tests_run++; if (pix(wdata_a[0], 1, 0) !== 8'h0A) begin tests_failed++; $display("FAIL wrap_pix1_0: got %h expected 0a", pix(wdata_a[0], 1, 0)); end
    tests_run++;
    if (wdata_a[0] !== ex) begin
      tests_failed++; d = first_diff(wdata_a[0], ex);
      $display("FAIL wrap_window: pixel %0d got %h expected %h", d, wdata_a[0][d*8 +: 8], ex[d*8 +: 8]);
    end
    $display("[TB] wrap: window across address 0x1fffff captured");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests_run++; if (rd_req_a !== 3'b111) begin tests_failed++; $display("FAIL rstmid_active: got %b expected 111", rd_req_a); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ({rd_req_a, busy_a, valid_a, rerr_a} !== 12'h000) begin tests_failed++; $display("FAIL rstmid_ctrl: got %h expected 000", {rd_req_a, busy_a, valid_a, rerr_a}); end
    tests_run++; if (req_addr_a !== '0) begin tests_failed++; $display("FAIL rstmid_req_addr: got %h expected 0", req_addr_a); end
    tests_run++; if (wdata_a !== '0) begin tests_failed++; $display("FAIL rstmid_win_data: got nonzero expected 0"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if ({rd_req_a, busy_a, valid_a} !== 9'h000) begin tests_failed++; $display("FAIL rstmid_after: got %h expected 000", {rd_req_a, busy_a, valid_a}); end
    $display("[TB] reset_mid: reset at cycle 20 cleared all outputs");
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    start = 1'b0; abort = 1'b0; base = '0; row = '0; col = '0; mode = 0;
    test_reset();
    test_basic();
    test_offset();
    test_range();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
